// File: rtl/seg7_scan_display_if.sv
// Host-side load bus for the multiplexed seven-segment driver: shadow-load strobe,
// hex word, decimal points, plus commit status back to the host.
interface seg7_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] Data;
  logic [NUM_DIGITS-1:0]   DpIn;
  logic                    Pending;
  logic                    FrameStart;

  modport master (output Load, Data, DpIn, input Pending, FrameStart);
  modport slave  (input Load, Data, DpIn, output Pending, FrameStart);
endinterface

// File: rtl/seg7_scan_display.sv
// N-digit multiplexed seven-segment driver with frame-synchronous shadow commit,
// per-digit decimal points, leading-zero blanking and inter-digit ghost blanking.
module seg7_scan_display #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 2000,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  seg7_scan_display_if.slave    host,
  output logic [NUM_DIGITS-1:0] en_out,
  output logic [6:0]            out7,
  output logic                  dp_out
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_pending;
  logic                    r_frame_start;
  logic [NUM_DIGITS-1:0]   r_en;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                  w_tick;
  logic                  w_frame;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tick  = (r_presc == LAST_PRESC);
  assign w_frame = w_tick && (r_idx == LAST_IDX);
  assign w_nib   = r_disp_data[4*r_idx +: 4];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Commit reads the shadow before this cycle's Load overwrites it, so a load
  // coinciding with the boundary waits a full frame with Pending still set.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sh_data     <= '0;
      r_sh_dp       <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame;
      if (w_frame && r_pending) begin
        r_disp_data <= r_sh_data;
        r_disp_dp   <= r_sh_dp;
        r_pending   <= 1'b0;
      end
      if (host.Load) begin
        r_sh_data <= host.Data;
        r_sh_dp   <= host.DpIn;
        r_pending <= 1'b1;
      end
    end
  end

  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    logic v_run;
    int unsigned v_pos;
    w_blank = '0;
    v_run   = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      v_pos          = NUM_DIGITS - 1 - k;
      v_run          = v_run & (r_disp_data[4*v_pos +: 4] == 4'h0);
      w_blank[v_pos] = v_run && (BLANK_LZ != 0);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_en  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else if (r_presc < BLANK_END) begin
      r_en  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_en  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_blank[r_idx] ? 7'h7F : hex7(w_nib);
      r_dp  <= ~r_disp_dp[r_idx];
    end
  end

  assign en_out          = r_en;
  assign out7            = r_seg;
  assign dp_out          = r_dp;
  assign host.Pending    = r_pending;
  assign host.FrameStart = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (4 digits, 8-cycle slots, 2-cycle ghost blank).
// Expected samples are queued per cycle index; a negedge monitor pops and compares.
module tb_seg7_scan_display;

  localparam int unsigned ND = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [ND-1:0] en_out;
  logic [6:0]    out7;
  logic          dp_out;

  seg7_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .BLANK_LZ  (1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .host  (bus.slave),
    .en_out(en_out),
    .out7  (out7),
    .dp_out(dp_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    bit          full;
    logic [3:0]  en;
    logic [6:0]  seg;
    logic        dp;
    logic        pend;
    logic        fs;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;

  // Cycle index: number of rising edges since Reset was released.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge Clk) begin
    exp_t e;
    bit   ok;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: sample for cycle %0d never compared (now at cycle %0d)", e.name, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      ok = (en_out === e.en) && (bus.Pending === e.pend) && (bus.FrameStart === e.fs);
      if (e.full) ok = ok && (out7 === e.seg) && (dp_out === e.dp);
      if (!ok) begin
        errors++;
        $display("FAIL %s @cyc %0d: got en=%h seg=%h dp=%b pend=%b fs=%b, want en=%h seg=%h dp=%b pend=%b fs=%b%s",
                 e.name, cyc, en_out, out7, dp_out, bus.Pending, bus.FrameStart,
                 e.en, e.seg, e.dp, e.pend, e.fs, e.full ? "" : " (seg/dp not checked)");
      end
    end
  end

  task automatic push(input int unsigned c, input bit full, input logic [3:0] en,
                      input logic [6:0] seg, input logic dp, input logic pend,
                      input logic fs, input string nm);
    exp_t e;
    e.cyc = c; e.full = full; e.en = en; e.seg = seg;
    e.dp = dp; e.pend = pend; e.fs = fs; e.name = nm;
    q.push_back(e);
  endtask

  // Samples 1..8 of slot d in frame f; first two samples are the ghost blank.
  task automatic push_slot(input int unsigned f, input int unsigned d, input logic [6:0] seg,
                           input logic dpbit, input logic pend, input logic pend_last);
    logic [3:0]  an_tab [4];
    int unsigned base;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    base   = 32*f + 8*d + 1;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < 2)
        push(base + k, 1'b0, 4'hF, 7'h7F, 1'b1, pend, 1'b0,
             $sformatf("f%0d_d%0d_blank%0d", f, d, k));
      else
        push(base + k, 1'b1, an_tab[d], seg, ~dpbit, (k == 7) ? pend_last : pend,
             (d == 3) && (k == 7), $sformatf("f%0d_d%0d_s%0d", f, d, k));
    end
  endtask

  // segs packed {d3,d2,d1,d0}; dp/pend indexed by digit.
  task automatic push_frame(input int unsigned f, input logic [27:0] segs, input logic [3:0] dp,
                            input logic [3:0] pend, input logic pend_last);
    for (int unsigned d = 0; d < 4; d++)
      push_slot(f, d, segs[7*d +: 7], dp[d], pend[d], (d == 3) ? pend_last : pend[d]);
  endtask

  task automatic wait_cyc(input int unsigned target);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (cyc != target && n < 1000);
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, target);
    end
  endtask

  task automatic do_load(input int unsigned l, input logic [15:0] data, input logic [3:0] dp);
    wait_cyc(l - 1);
    bus.Load = 1'b1;
    bus.Data = data;
    bus.DpIn = dp;
    wait_cyc(l);
    bus.Load = 1'b0;
  endtask

  initial begin
    int n;
    bus.Load = 1'b0;
    bus.Data = '0;
    bus.DpIn = '0;
    Reset    = 1'b0;

    repeat (5) @(posedge Clk);
    push(0, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, "reset_hold");
    @(negedge Clk);
    Reset = 1'b1;

    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, 4'b1110, 1'b0);
    do_load(9, 16'h1234, 4'b0001);
    push_frame(1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0001, 4'b1110, 1'b0);
    do_load(41, 16'h0050, 4'b0000);
    push_frame(2, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000, 4'b1110, 1'b0);
    do_load(73, 16'h0000, 4'b0000);
    push_frame(3, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, 4'b1110, 1'b0);
    do_load(105, 16'hAAAA, 4'b0000);
    do_load(113, 16'hBBBB, 4'b1010);
    push_frame(4, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1010, 4'b1110, 1'b1);
    do_load(137, 16'h5678, 4'b0000);
    do_load(160, 16'hCCCC, 4'b0100);
    push_frame(5, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000, 4'b1111, 1'b0);
    push_frame(6, {7'h46, 7'h46, 7'h46, 7'h46}, 4'b0100, 4'b0000, 1'b0);

    wait_cyc(232);
    @(posedge Clk);
    #2 Reset = 1'b0;
    push(0, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, "async_reset_midslot");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    push_slot(0, 0, 7'h40, 1'b0, 1'b0, 1'b0);
    push_slot(0, 1, 7'h7F, 1'b0, 1'b0, 1'b0);
    wait_cyc(17);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
